core_pipe_exec_divseq: RTL and testbench

Iterative restoring divide sequencer for the execute stage: accepts DIV/DIVU/REM/REMU (and W variants) from the pipeline, then takes over the shared integer ALU adder for one subtract per cycle until the quotient or remainder is ready. It owns only the control, counter and the quotient/remainder registers. The ALU stays external and is muxed to this block while `alu_busy` is high. XLEN = 64.

---
 rtl/core_pipe_exec_divseq_pkg.sv | 30 +++
 rtl/core_pipe_exec_divseq_if.sv | 38 +++
 rtl/core_pipe_exec_divseq.sv | 191 +++++++++++++++++++
 tb/tb_core_pipe_exec_divseq.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pipe_exec_divseq_pkg.sv
// rtl/core_pipe_exec_divseq_pkg.sv - shared constants, state encoding and helpers for the divide sequencer
package core_pipe_exec_divseq_pkg;

    localparam int XLEN  = 64;
    localparam int XL    = XLEN - 1;
    localparam int CNT_W = 6;

    // Most-negative dividend patterns after operand extension
    localparam logic [XL:0] MIN_NEG_D = 64'h8000_0000_0000_0000;
    localparam logic [XL:0] MIN_NEG_W = 64'hFFFF_FFFF_8000_0000;

    // Loop counter start values (N-1)
    localparam logic [CNT_W-1:0] CNT_START_D = 6'd63;
    localparam logic [CNT_W-1:0] CNT_START_W = 6'd31;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_NEG_A = 3'd1,
        ST_NEG_B = 3'd2,
        ST_LOOP  = 3'd3,
        ST_FIX   = 3'd4,
        ST_DONE  = 3'd5
    } div_state_e;

    // Extend the low word to XLEN, sign- or zero-filling from bit 31
    function automatic logic [XL:0] word_ext(input logic [XL:0] x, input logic sgn);
        return {{32{sgn & x[31]}}, x[31:0]};
    endfunction

endpackage

// File: rtl/core_pipe_exec_divseq_if.sv
// rtl/core_pipe_exec_divseq_if.sv - request/response and shared-ALU signal bundle for the divide sequencer
interface core_pipe_exec_divseq_if;
    import core_pipe_exec_divseq_pkg::*;

    logic          flush;
    logic          req_valid;
    logic          req_ready;
    logic [XL:0]   req_a;
    logic [XL:0]   req_b;
    logic          req_signed;
    logic          req_rem;
    logic          req_word;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [XL:0]   rsp_data;
    logic          alu_busy;
    logic [XL:0]   alu_opr_a;
    logic [XL:0]   alu_opr_b;
    logic          alu_op_sub;
    logic [XL:0]   alu_add_out;

    // Pipeline / ALU owner side
    modport master (
        output flush, req_valid, req_a, req_b, req_signed, req_rem, req_word,
        output rsp_ready, alu_add_out,
        input  req_ready, rsp_valid, rsp_data,
        input  alu_busy, alu_opr_a, alu_opr_b, alu_op_sub
    );

    // Divide sequencer side
    modport slave (
        input  flush, req_valid, req_a, req_b, req_signed, req_rem, req_word,
        input  rsp_ready, alu_add_out,
        output req_ready, rsp_valid, rsp_data,
        output alu_busy, alu_opr_a, alu_opr_b, alu_op_sub
    );

endinterface

// File: rtl/core_pipe_exec_divseq.sv
// rtl/core_pipe_exec_divseq.sv - iterative restoring divide sequencer borrowing the shared integer ALU
module core_pipe_exec_divseq
    import core_pipe_exec_divseq_pkg::*;
(
    input  logic                    g_clk,
    input  logic                    g_rst,
    core_pipe_exec_divseq_if.slave  io
);

    div_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [XL:0]        quo_q, quo_d;
    logic [XL:0]        rem_q, rem_d;
    logic [XL:0]        b_q, b_d;
    logic               sgn_q, sgn_d;
    logic               rem_sel_q, rem_sel_d;
    logic               word_q, word_d;
    logic               a_neg_q, a_neg_d;
    logic               b_neg_q, b_neg_d;

    logic [XL:0]        a_ext, b_ext;
    logic               a_is_min, b_is_m1, b_is_zero;
    logic [XL:0]        rs;
    logic               cy;
    logic               take;
    logic [XL:0]        res_sel;
    logic               res_neg;

    // Operand extension and special-case detection on the incoming request
    always_comb begin
        a_ext     = io.req_word ? word_ext(io.req_a, io.req_signed) : io.req_a;
        b_ext     = io.req_word ? word_ext(io.req_b, io.req_signed) : io.req_b;
        a_is_min  = (a_ext == (io.req_word ? MIN_NEG_W : MIN_NEG_D));
        b_is_m1   = &b_ext;
        b_is_zero = (b_ext == '0);
    end

    // Shift-in of the next dividend bit and restore decision for one loop step
    always_comb begin
        if (word_q) begin
            rs = {32'b0, rem_q[30:0], quo_q[31]};
            cy = rem_q[31];
        end else begin
            rs = {rem_q[XL-1:0], quo_q[XL]};
            cy = rem_q[XL];
        end
        take    = cy | (rs >= b_q);
        res_sel = rem_sel_q ? rem_q : quo_q;
        // Remainder follows the dividend sign; quotient is negative on opposite signs
        res_neg = sgn_q & (rem_sel_q ? a_neg_q : (a_neg_q ^ b_neg_q));
    end

    // Next-state, datapath register updates and ALU operand mux
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        quo_d         = quo_q;
        rem_d         = rem_q;
        b_d           = b_q;
        sgn_d         = sgn_q;
        rem_sel_d     = rem_sel_q;
        word_d        = word_q;
        a_neg_d       = a_neg_q;
        b_neg_d       = b_neg_q;
        io.alu_busy   = 1'b0;
        io.alu_opr_a  = '0;
        io.alu_opr_b  = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (io.req_valid && !io.flush) begin
                    b_d       = b_ext;
                    sgn_d     = io.req_signed;
                    rem_sel_d = io.req_rem;
                    word_d    = io.req_word;
                    a_neg_d   = io.req_signed & a_ext[XL];
                    b_neg_d   = io.req_signed & b_ext[XL];
                    cnt_d     = io.req_word ? CNT_START_W : CNT_START_D;
                    if (b_is_zero) begin
                        quo_d   = '1;
                        rem_d   = a_ext;
                        state_d = ST_DONE;
                    end else if (io.req_signed && a_is_min && b_is_m1) begin
                        quo_d   = a_ext;
                        rem_d   = '0;
                        state_d = ST_DONE;
                    end else begin
                        quo_d = a_ext;
                        rem_d = '0;
                        if (io.req_signed && a_ext[XL]) begin
                            state_d = ST_NEG_A;
                        end else if (io.req_signed && b_ext[XL]) begin
                            state_d = ST_NEG_B;
                        end else begin
                            state_d = ST_LOOP;
                        end
                    end
                end
            end
            ST_NEG_A: begin
                // Dividend magnitude lives in the quotient register until shifted out
                io.alu_busy  = 1'b1;
                io.alu_opr_b = quo_q;
                quo_d        = io.alu_add_out;
                state_d      = b_neg_q ? ST_NEG_B : ST_LOOP;
            end
            ST_NEG_B: begin
                io.alu_busy  = 1'b1;
                io.alu_opr_b = b_q;
                b_d          = io.alu_add_out;
                state_d      = ST_LOOP;
            end
            ST_LOOP: begin
                io.alu_busy  = 1'b1;
                io.alu_opr_a = rs;
                io.alu_opr_b = b_q;
                if (take) begin
                    // Word ops keep the partial remainder in the low half only
                    rem_d = word_q ? {32'b0, io.alu_add_out[31:0]} : io.alu_add_out;
                end else begin
                    rem_d = rs;
                end
                quo_d = {quo_q[XL-1:0], take};
                if (cnt_q == '0) begin
                    state_d = res_neg ? ST_FIX : ST_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_FIX: begin
                io.alu_busy  = 1'b1;
                io.alu_opr_b = res_sel;
                if (rem_sel_q) begin
                    rem_d = io.alu_add_out;
                end else begin
                    quo_d = io.alu_add_out;
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (io.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Flush abandons the operation and wins over the response handshake
        if (io.flush) begin
            state_d = ST_IDLE;
        end
    end

    // Handshake and result outputs derived from registered state
    always_comb begin
        io.alu_op_sub = io.alu_busy;
        io.req_ready  = (state_q == ST_IDLE);
        io.rsp_valid  = (state_q == ST_DONE);
        io.rsp_data   = word_q ? word_ext(res_sel, 1'b1) : res_sel;
    end

    // State and datapath registers
    always_ff @(posedge g_clk or posedge g_rst) begin
        if (g_rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            b_q       <= '0;
            sgn_q     <= 1'b0;
            rem_sel_q <= 1'b0;
            word_q    <= 1'b0;
            a_neg_q   <= 1'b0;
            b_neg_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            b_q       <= b_d;
            sgn_q     <= sgn_d;
            rem_sel_q <= rem_sel_d;
            word_q    <= word_d;
            a_neg_q   <= a_neg_d;
            b_neg_q   <= b_neg_d;
        end
    end

endmodule

// File: tb/tb_core_pipe_exec_divseq.sv
// tb/tb_core_pipe_exec_divseq.sv - scoreboard bench for the divide sequencer with an arithmetic reference model
module tb_core_pipe_exec_divseq;
    import core_pipe_exec_divseq_pkg::*;

    typedef struct {
        logic [63:0] data;
        int          lat;
        int          id;
    } exp_t;

    logic g_clk = 1'b0;
    logic g_rst;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   rr_mode = 0;
    int   op_id = 0;
    exp_t exp_q[$];

    core_pipe_exec_divseq_if bus();

    core_pipe_exec_divseq dut (
        .g_clk (g_clk),
        .g_rst (g_rst),
        .io    (bus)
    );

    always #5 g_clk = ~g_clk;

    // Parent-owned ALU adder
    assign bus.alu_add_out = bus.alu_op_sub ? (bus.alu_opr_a - bus.alu_opr_b)
                                            : (bus.alu_opr_a + bus.alu_opr_b);

    always @(posedge g_clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    // Architectural result of DIV/DIVU/REM/REMU and W variants
    function automatic logic [63:0] ref_result(input logic [63:0] a, input logic [63:0] b,
                                               input logic sgn, input logic rm, input logic wd);
        logic [31:0] a32, b32, r32;
        int          sa, sb;
        longint      la, lb;
        logic [63:0] r64;
        if (wd) begin
            a32 = a[31:0];
            b32 = b[31:0];
            if (b32 == 32'd0) begin
                r32 = rm ? a32 : 32'hFFFF_FFFF;
            end else if (sgn && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
                r32 = rm ? 32'd0 : a32;
            end else if (sgn) begin
                sa  = a32;
                sb  = b32;
                r32 = rm ? (sa % sb) : (sa / sb);
            end else begin
                r32 = rm ? (a32 % b32) : (a32 / b32);
            end
            return {{32{r32[31]}}, r32};
        end
        if (b == 64'd0) begin
            r64 = rm ? a : 64'hFFFF_FFFF_FFFF_FFFF;
        end else if (sgn && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) begin
            r64 = rm ? 64'd0 : a;
        end else if (sgn) begin
            la  = a;
            lb  = b;
            r64 = rm ? (la % lb) : (la / lb);
        end else begin
            r64 = rm ? (a % b) : (a / b);
        end
        return r64;
    endfunction

    // Cycles from accept edge to first response cycle
    function automatic int ref_lat(input logic [63:0] a, input logic [63:0] b,
                                   input logic sgn, input logic rm, input logic wd);
        bit an, bn, bz, ovf;
        an  = sgn && (wd ? a[31] : a[63]);
        bn  = sgn && (wd ? b[31] : b[63]);
        bz  = wd ? (b[31:0] == 32'd0) : (b == 64'd0);
        ovf = sgn && (wd ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                         : (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF));
        if (bz || ovf) return 1;
        return (wd ? 33 : 65) + int'(an) + int'(bn) + int'(sgn && (rm ? an : (an ^ bn)));
    endfunction

    function automatic logic [63:0] rnd_opnd();
        logic [63:0] v;
        case ($urandom_range(0, 7))
            0: v = 64'd0;
            1: v = 64'hFFFF_FFFF_FFFF_FFFF;
            2: v = 64'h8000_0000_0000_0000;
            3: v = 64'h0000_0000_8000_0000;
            4: v = 64'($urandom_range(0, 20));
            5: v = 64'd0 - 64'($urandom_range(1, 20));
            default: v = {$urandom, $urandom};
        endcase
        return v;
    endfunction

    task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic sgn,
                         input logic rm, input logic wd, input bit expect_rsp);
        exp_t e;
        int   to;
        e.data = ref_result(a, b, sgn, rm, wd);
        e.lat  = ref_lat(a, b, sgn, rm, wd);
        e.id   = op_id;
        op_id++;
        @(posedge g_clk);
        #1;
        bus.req_a      = a;
        bus.req_b      = b;
        bus.req_signed = sgn;
        bus.req_rem    = rm;
        bus.req_word   = wd;
        bus.req_valid  = 1'b1;
        to = 0;
        @(negedge g_clk);
        while (!bus.req_ready && to < 300) begin
            @(negedge g_clk);
            to++;
        end
        if (!bus.req_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout op %0d: req_ready stayed 0, required 1", e.id);
        end else if (expect_rsp) begin
            exp_q.push_back(e);
        end
        @(posedge g_clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !bus.req_ready) && n < limit) begin
            @(negedge g_clk);
            n++;
        end
        chk("drain_pending", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"},  64'(bus.req_ready),  64'd1);
        chk({tag, "_rsp_valid"},  64'(bus.rsp_valid),  64'd0);
        chk({tag, "_rsp_data"},   bus.rsp_data,        64'd0);
        chk({tag, "_alu_busy"},   64'(bus.alu_busy),   64'd0);
        chk({tag, "_alu_op_sub"}, 64'(bus.alu_op_sub), 64'd0);
        chk({tag, "_alu_opr_a"},  bus.alu_opr_a,       64'd0);
        chk({tag, "_alu_opr_b"},  bus.alu_opr_b,       64'd0);
    endtask

    // Backpressure driver for rsp_ready
    initial begin
        bus.rsp_ready = 1'b1;
        forever begin
            @(posedge g_clk);
            #1;
            case (rr_mode)
                0:       bus.rsp_ready = 1'b1;
                1:       bus.rsp_ready = 1'($urandom_range(0, 1));
                default: bus.rsp_ready = 1'b0;
            endcase
        end
    end

    // Monitor: ALU mux rules, response stability and scoreboard pop
    int          acc_cyc = 0;
    int          first_cyc = 0;
    int          busy_cnt = 0;
    bit          in_rsp = 0;
    logic [63:0] held = '0;
    always @(negedge g_clk) begin
        exp_t e;
        if (g_rst) begin
            in_rsp = 0;
        end else begin
            chk("op_sub_eq_busy", 64'(bus.alu_op_sub), 64'(bus.alu_busy));
            if (!bus.alu_busy) begin
                chk("idle_opr", bus.alu_opr_a | bus.alu_opr_b, 64'd0);
            end
            if (bus.alu_busy) busy_cnt++;
            if (bus.rsp_valid) begin
                if (!in_rsp) begin
                    in_rsp    = 1;
                    first_cyc = cyc;
                    held      = bus.rsp_data;
                end else begin
                    chk("rsp_data_stable", bus.rsp_data, held);
                end
                chk("req_ready_in_done", 64'(bus.req_ready), 64'd0);
                if (bus.rsp_ready && !bus.flush) begin
                    in_rsp = 0;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_rsp: got data %h with no request outstanding", bus.rsp_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk($sformatf("rsp_data op %0d", e.id), bus.rsp_data, e.data);
                        chk($sformatf("latency op %0d", e.id), 64'(first_cyc - acc_cyc + 1), 64'(e.lat));
                        chk($sformatf("busy_cycles op %0d", e.id), 64'(busy_cnt), 64'(e.lat - 1));
                    end
                end
            end
            if (bus.req_valid && bus.req_ready && !bus.flush) begin
                acc_cyc  = cyc + 1;
                busy_cnt = 0;
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        g_rst          = 1'b1;
        bus.flush      = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.req_signed = 1'b0;
        bus.req_rem    = 1'b0;
        bus.req_word   = 1'b0;
        repeat (3) @(posedge g_clk);
        #1 g_rst = 1'b0;
        @(negedge g_clk);
        chk_reset_outputs("reset");

        // Directed cases
        issue(64'd100, 64'd7, 1'b0, 1'b0, 1'b0, 1'b1);
        issue(64'd100, 64'd7, 1'b0, 1'b1, 1'b0, 1'b1);
        issue(64'd0 - 64'd100, 64'd7, 1'b1, 1'b0, 1'b0, 1'b1);
        issue(64'd0 - 64'd100, 64'd7, 1'b1, 1'b1, 1'b0, 1'b1);
        issue(64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b1);
        issue(64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b1, 1'b1);
        issue(64'd5, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        issue(64'd5, 64'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        issue(64'h1234_5678_FFFF_FFF0, 64'h0000_0000_0000_0003, 1'b0, 1'b0, 1'b1, 1'b1);
        issue(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1);
        drain(200);

        // Flush during loop count 20
        issue(64'd1000, 64'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (43) @(posedge g_clk);
        #1 bus.flush = 1'b1;
        @(posedge g_clk);
        #1 bus.flush = 1'b0;
        @(negedge g_clk);
        chk("flush_req_ready", 64'(bus.req_ready), 64'd1);
        chk("flush_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("flush_alu_busy",  64'(bus.alu_busy),  64'd0);
        issue(64'd9, 64'd3, 1'b0, 1'b0, 1'b0, 1'b1);
        drain(200);

        // Flush alongside a request in IDLE is not an accept
        @(posedge g_clk);
        #1;
        bus.req_a = 64'd8; bus.req_b = 64'd2; bus.req_signed = 1'b0;
        bus.req_rem = 1'b0; bus.req_word = 1'b0;
        bus.req_valid = 1'b1; bus.flush = 1'b1;
        @(posedge g_clk);
        #1;
        bus.req_valid = 1'b0; bus.flush = 1'b0;
        @(negedge g_clk);
        chk("flush_req_not_taken", 64'(bus.alu_busy | bus.rsp_valid | !bus.req_ready), 64'd0);

        // Backpressure hold in DONE
        rr_mode = 2;
        issue(64'd1234, 64'd10, 1'b0, 1'b0, 1'b0, 1'b1);
        n = 0;
        while (!bus.rsp_valid && n < 100) begin
            @(negedge g_clk);
            n++;
        end
        chk("hold_rsp_arrived", 64'(bus.rsp_valid), 64'd1);
        repeat (10) begin
            @(negedge g_clk);
            chk("hold_rsp_valid", 64'(bus.rsp_valid), 64'd1);
            chk("hold_req_ready", 64'(bus.req_ready), 64'd0);
        end
        rr_mode = 0;
        drain(50);

        // Asynchronous reset in the middle of the loop
        issue(64'hFFFF_0000_1234_5678, 64'd77, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (10) @(posedge g_clk);
        #1 g_rst = 1'b1;
        #1 chk_reset_outputs("midloop_reset");
        @(posedge g_clk);
        #1 g_rst = 1'b0;

        // Randomized traffic with random backpressure
        rr_mode = 1;
        for (int i = 0; i < 150; i++) begin
            issue(rnd_opnd(), rnd_opnd(), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
        end
        drain(500);
        rr_mode = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
